// File: rtl/muldiv_unit_if.sv
// Handshake and result bus between the control unit and the iterative multiply/divide unit.
// The unit binds to the slave modport; the control unit (or a bench) drives the master side.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide sharing one 2W+1 bit accumulator.
// Operands are made non-negative on entry; signs are re-applied in a single FIX cycle.
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clock,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand conditioning: op[0]==0 selects the signed variants.
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_abs, b_abs;

  assign sign_a = ~bus.op[0] & bus.a[WIDTH-1];
  assign sign_b = ~bus.op[0] & bus.b[WIDTH-1];
  assign a_abs  = sign_a ? -bus.a : bus.a;
  assign b_abs  = sign_b ? -bus.b : bus.b;

  // Multiply keeps the partial product in the upper half and the multiplier in the lower half;
  // divide keeps the partial remainder in the upper half and dividend/quotient in the lower half.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign prod     = acc_q[2*WIDTH-1:0];
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          div_zero_d = 1'b0;
          if (bus.op[1] && (bus.b == '0)) begin
            div_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            is_div_d  = bus.op[1];
            cnt_d     = '0;
            neg_d     = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            if (bus.op[1]) begin
              acc_d  = {{(WIDTH+1){1'b0}}, a_abs};
              opnd_d = b_abs;
            end else begin
              acc_d  = {{(WIDTH+1){1'b0}}, b_abs};
              opnd_d = a_abs;
            end
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (is_div_q) begin
          // Restoring step: keep the shifted remainder when the trial subtraction goes negative.
          if (rem_diff[WIDTH]) acc_d = {rem_sh, acc_q[WIDTH-2:0], 1'b0};
          else                 acc_d = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end

      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = DONE;
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      acc_q      <= '0;
      opnd_q     <= '0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy     = (state_q == CALC) || (state_q == FIX);
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random operations on 32- and 8-bit instances,
// compared against a plain-arithmetic model of MULT/MULTU/DIV/DIVU.
module tb_muldiv_unit;

  localparam int W  = 32;
  localparam int W8 = 8;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  muldiv_unit_if #(.WIDTH(W))  bus  ();
  muldiv_unit_if #(.WIDTH(W8)) bus8 ();

  muldiv_unit #(.WIDTH(W))  dut  (.clock(clock), .reset(reset), .bus(bus));
  muldiv_unit #(.WIDTH(W8)) dut8 (.clock(clock), .reset(reset), .bus(bus8));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sampling/driving point: 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic longint sext(input logic [31:0] v, input int w);
    longint t;
    t = longint'(v) << (64 - w);
    return t >>> (64 - w);
  endfunction

  // Returns {hi, lo}, each field masked to w bits. Divisor must be non-zero.
  function automatic logic [63:0] model(input int w, input logic [1:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    longint mask, x, y, p, q, r;
    mask = (longint'(1) << w) - 1;
    x = op[0] ? (longint'(a) & mask) : sext(a, w);
    y = op[0] ? (longint'(b) & mask) : sext(b, w);
    if (!op[1]) begin
      p = x * y;
      return {32'((p >> w) & mask), 32'(p & mask)};
    end
    q = x / y;
    r = x % y;
    return {32'(r & mask), 32'(q & mask)};
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc, output bit busy_ok);
    cyc     = cyc0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      step();
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input int cyc, input bit busy_ok,
                              input int exp_cyc, input logic [W-1:0] exp_hi,
                              input logic [W-1:0] exp_lo, input logic exp_dz);
    check({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " busy_while_running"}, 64'(busy_ok), 64'd1);
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    check({tag, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
  endtask

  task automatic run32(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                       input logic [W-1:0] exp_lo, input int exp_cyc, input logic exp_dz);
    int cyc;
    bit busy_ok;
    issue(op, a, b);
    wait_done(1, cyc, busy_ok);
    check_result(tag, cyc, busy_ok, exp_cyc, exp_hi, exp_lo, exp_dz);
    step();
  endtask

  task automatic run8(input string tag, input logic [1:0] op, input logic [W8-1:0] a,
                      input logic [W8-1:0] b, input logic [W8-1:0] exp_hi,
                      input logic [W8-1:0] exp_lo);
    int cyc;
    bus8.start = 1'b1;
    bus8.op    = op;
    bus8.a     = a;
    bus8.b     = b;
    step();
    bus8.start = 1'b0;
    cyc = 1;
    while (bus8.done !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    check({tag, " done_cycle"}, 64'(cyc), 64'(W8 + 2));
    check({tag, " hi"}, 64'(bus8.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus8.lo), 64'(exp_lo));
    step();
  endtask

  initial begin
    logic [63:0] exp;
    logic [1:0]  op;
    logic [31:0] ra, rb;
    int          cyc;
    bit          busy_ok;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = '0;
    bus.a      = '0;
    bus.b      = '0;
    bus8.start = 1'b0;
    bus8.op    = '0;
    bus8.a     = '0;
    bus8.b     = '0;
    repeat (3) step();
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset div_zero", 64'(bus.div_zero), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    step();

    // Directed corner cases, 32-bit.
    run32("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, W + 2, 1'b0);
    run32("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001, W + 2, 1'b0);
    run32("divu_256_7", OP_DIVU, 32'h0000_0100, 32'h0000_0007,
          32'h0000_0004, 32'h0000_0024, W + 2, 1'b0);
    run32("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 2, 1'b0);
    run32("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0000_0000, 32'h8000_0000, W + 2, 1'b0);
    run32("divu_by_zero", OP_DIVU, 32'h0000_0007, 32'h0000_0000,
          32'h0000_0000, 32'h8000_0000, 1, 1'b1);
    run32("mult_clears_dz", OP_MULT, 32'h0000_0003, 32'h0000_0004,
          32'h0000_0000, 32'h0000_000C, W + 2, 1'b0);

    // Start pulse with new operands mid-operation must not disturb the running MULT.
    exp = model(W, OP_MULT, 32'h0001_2345, 32'hFFFF_0003);
    issue(OP_MULT, 32'h0001_2345, 32'hFFFF_0003);
    repeat (4) step();
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0000_0000;
    step();
    bus.start = 1'b0;
    wait_done(6, cyc, busy_ok);
    check_result("mid_start_ignored", cyc, busy_ok, W + 2, exp[63:32], exp[31:0], 1'b0);
    step();

    // Reset in cycle 10 aborts the operation; a start in the next cycle is accepted.
    issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort done", 64'(bus.done), 64'd0);
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort hi", 64'(bus.hi), 64'd0);
    check("abort lo", 64'(bus.lo), 64'd0);
    exp = model(W, OP_DIV, 32'hFFFF_FF9C, 32'h0000_0007);
    issue(OP_DIV, 32'hFFFF_FF9C, 32'h0000_0007);
    check("restart busy", 64'(bus.busy), 64'd1);
    wait_done(1, cyc, busy_ok);
    check_result("restart_div", cyc, busy_ok, W + 2, exp[63:32], exp[31:0], 1'b0);
    step();

    // Random operations, 32-bit.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 7) == 0) rb = ~rb + 32'd1;
      if (op[1] && rb == '0) rb = 32'd1;
      exp = model(W, op, ra, rb);
      run32($sformatf("rand32_%0d", i), op, ra, rb, exp[63:32], exp[31:0], W + 2, 1'b0);
    end

    // 8-bit instance: directed then random.
    run8("w8_mult_80x80", OP_MULT, 8'h80, 8'h80, 8'h40, 8'h00);
    run8("w8_div_81_03", OP_DIV, 8'h81, 8'h03, 8'hFF, 8'hD6);
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 255));
      rb = 32'($urandom_range(0, 255));
      if (op[1] && rb == '0) rb = 32'd1;
      exp = model(W8, op, ra, rb);
      run8($sformatf("rand8_%0d", i), op, ra[7:0], rb[7:0], exp[39:32], exp[7:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
